// File: rtl/btn_pulse_gen_if.sv
// rtl/btn_pulse_gen_if.sv - button-side and counter-side signals of btn_pulse_gen
//
// Purpose: bundles the raw button input with the conditioned outputs so the
// pulse generator can be connected as a single port.
// Signals:
//   btn_in    raw push-button level, asynchronous to clk, may bounce
//   pulse     one-cycle enable pulse for the downstream counter
//   btn_level debounced button level
//   repeating high while the hold-to-repeat FSM is in REPEAT
// Modports:
//   master  the board/pin side: drives btn_in, observes the outputs
//   slave   the pulse generator: samples btn_in, drives the outputs
interface btn_pulse_gen_if;
  logic btn_in;
  logic pulse;
  logic btn_level;
  logic repeating;

  modport master (
    output btn_in,
    input  pulse,
    input  btn_level,
    input  repeating
  );

  modport slave (
    input  btn_in,
    output pulse,
    output btn_level,
    output repeating
  );
endinterface

// File: rtl/btn_pulse_gen.sv
// rtl/btn_pulse_gen.sv - button synchronizer, debouncer and hold-to-repeat pulse generator
//
// Purpose: turns a raw, bouncing push-button into clean single-cycle enable
// pulses: one pulse on press, then (optionally) repeat pulses while held.
// Ports:
//   clk  system clock, rising edge
//   rst  asynchronous, active-high reset
//   bus  btn_pulse_gen_if.slave: btn_in in; pulse, btn_level, repeating out
module btn_pulse_gen #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned REPEAT_DELAY    = 25000000,
  parameter int unsigned REPEAT_PERIOD   = 5000000,
  parameter bit          REPEAT_EN       = 1'b1,
  parameter int unsigned CNT_W           = 26
) (
  input  logic            clk,
  input  logic            rst,
  btn_pulse_gen_if.slave  bus
);

  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    REPEAT = 2'd2
  } state_t;

  logic             s1_q, s2_q;
  logic [CNT_W-1:0] dcnt_q, dcnt_d;
  logic             level_q, level_d;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] rtmr_q, rtmr_d;
  logic             pulse_q, pulse_d;
  logic             repeating_q;
  logic             rise, fall;

  // Debounce: the level only flips after s2 has disagreed with it for
  // DEBOUNCE_CYCLES consecutive edges; any agreement restarts the count.
  always_comb begin
    dcnt_d  = '0;
    level_d = level_q;
    if (s2_q != level_q) begin
      if (dcnt_q == DB_LAST) begin
        level_d = s2_q;
      end else begin
        dcnt_d = dcnt_q + CNT_ONE;
      end
    end
  end

  // Events are taken from the next level so the FSM reacts on the very
  // edge that flips btn_level, keeping pulse aligned with the rise.
  assign rise = level_d & ~level_q;
  assign fall = ~level_d & level_q;

  always_comb begin
    state_d = state_q;
    rtmr_d  = rtmr_q;
    pulse_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (rise) begin
          pulse_d = 1'b1;
          rtmr_d  = '0;
          state_d = HOLD;
        end
      end
      HOLD: begin
        // Release is checked first so it overrides a coinciding expiry.
        if (fall) begin
          rtmr_d  = '0;
          state_d = IDLE;
        end else if (REPEAT_EN) begin
          if (rtmr_q == DLY_LAST) begin
            pulse_d = 1'b1;
            rtmr_d  = '0;
            state_d = REPEAT;
          end else begin
            rtmr_d = rtmr_q + CNT_ONE;
          end
        end
      end
      REPEAT: begin
        if (fall) begin
          rtmr_d  = '0;
          state_d = IDLE;
        end else if (rtmr_q == PER_LAST) begin
          pulse_d = 1'b1;
          rtmr_d  = '0;
        end else begin
          rtmr_d = rtmr_q + CNT_ONE;
        end
      end
      default: begin
        rtmr_d  = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q        <= 1'b0;
      s2_q        <= 1'b0;
      dcnt_q      <= '0;
      level_q     <= 1'b0;
      state_q     <= IDLE;
      rtmr_q      <= '0;
      pulse_q     <= 1'b0;
      repeating_q <= 1'b0;
    end else begin
      s1_q        <= bus.btn_in;
      s2_q        <= s1_q;
      dcnt_q      <= dcnt_d;
      level_q     <= level_d;
      state_q     <= state_d;
      rtmr_q      <= rtmr_d;
      pulse_q     <= pulse_d;
      repeating_q <= (state_d == REPEAT);
    end
  end

  assign bus.pulse     = pulse_q;
  assign bus.btn_level = level_q;
  assign bus.repeating = repeating_q;

endmodule

// File: tb/tb_btn_pulse_gen.sv
// tb/tb_btn_pulse_gen.sv - directed self-checking bench for btn_pulse_gen
module tb_btn_pulse_gen;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  btn_pulse_gen_if bus ();
  btn_pulse_gen_if bus2 ();

  btn_pulse_gen #(
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY   (10),
    .REPEAT_PERIOD  (3),
    .REPEAT_EN      (1'b1),
    .CNT_W          (8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  btn_pulse_gen #(
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY   (10),
    .REPEAT_PERIOD  (3),
    .REPEAT_EN      (1'b0),
    .CNT_W          (8)
  ) dut_norep (
    .clk(clk),
    .rst(rst),
    .bus(bus2.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance past the next rising edge; sampling and driving happen 1 ns later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.btn_in  = 1'b0;
    bus2.btn_in = 1'b0;
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    repeat (2) step();
  endtask

  task automatic test_reset();
    bus.btn_in  = 1'b1;
    bus2.btn_in = 1'b1;
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      total++;
      if (bus.pulse !== 1'b0 || bus.btn_level !== 1'b0 || bus.repeating !== 1'b0) begin
        bad++;
        $display("FAIL reset cyc%0d: pulse=%b level=%b rep=%b required 0 0 0",
                 c, bus.pulse, bus.btn_level, bus.repeating);
      end
      total++;
      if (bus2.pulse !== 1'b0 || bus2.btn_level !== 1'b0 || bus2.repeating !== 1'b0) begin
        bad++;
        $display("FAIL reset_norep cyc%0d: pulse=%b level=%b rep=%b required 0 0 0",
                 c, bus2.pulse, bus2.btn_level, bus2.repeating);
      end
    end
    do_reset();
  endtask

  // Button high for hold_n sampled edges (edges 0..hold_n-1).
  task automatic test_glitch(input int hold_n, input bit expect_flip);
    logic exp_p, exp_l;
    for (int e = 0; e < 16; e++) begin
      bus.btn_in = (e < hold_n);
      step();
      exp_p = expect_flip && (e == 5);
      exp_l = expect_flip && (e >= 5) && (e <= 8);
      total++;
      if (bus.pulse !== exp_p) begin
        bad++;
        $display("FAIL glitch%0d_pulse e%0d: got %b required %b", hold_n, e, bus.pulse, exp_p);
      end
      total++;
      if (bus.btn_level !== exp_l) begin
        bad++;
        $display("FAIL glitch%0d_level e%0d: got %b required %b", hold_n, e, bus.btn_level, exp_l);
      end
    end
    do_reset();
  endtask

  task automatic test_short_press();
    logic exp_l;
    for (int e = 0; e < 20; e++) begin
      bus.btn_in = (e < 8);
      step();
      exp_l = (e >= 5) && (e < 13);
      total++;
      if (bus.pulse !== (e == 5)) begin
        bad++;
        $display("FAIL short_pulse e%0d: got %b required %b", e, bus.pulse, (e == 5));
      end
      total++;
      if (bus.btn_level !== exp_l || bus.repeating !== 1'b0) begin
        bad++;
        $display("FAIL short_level_rep e%0d: level=%b rep=%b required %b 0",
                 e, bus.btn_level, bus.repeating, exp_l);
      end
    end
    do_reset();
  endtask

  // Released after edge 25: fall at edge 31, clear of any repeat tick.
  task automatic test_hold();
    logic exp_p, exp_r;
    for (int e = 0; e < 40; e++) begin
      bus.btn_in = (e < 26);
      step();
      exp_p = (e == 5) || (e == 15) || (e == 18) || (e == 21) ||
              (e == 24) || (e == 27) || (e == 30);
      exp_r = (e >= 15) && (e < 31);
      total++;
      if (bus.pulse !== exp_p) begin
        bad++;
        $display("FAIL hold_pulse e%0d: got %b required %b", e, bus.pulse, exp_p);
      end
      total++;
      if (bus.repeating !== exp_r) begin
        bad++;
        $display("FAIL hold_repeating e%0d: got %b required %b", e, bus.repeating, exp_r);
      end
    end
    do_reset();
  endtask

  // Released after edge 27: fall lands on edge 33 where rtmr==2 would tick.
  task automatic test_release_collision();
    logic exp_p, exp_r;
    for (int e = 0; e < 40; e++) begin
      bus.btn_in = (e < 28);
      step();
      exp_p = (e == 5) || (e == 15) || (e == 18) || (e == 21) ||
              (e == 24) || (e == 27) || (e == 30);
      exp_r = (e >= 15) && (e < 33);
      total++;
      if (bus.pulse !== exp_p) begin
        bad++;
        $display("FAIL collision_pulse e%0d: got %b required %b", e, bus.pulse, exp_p);
      end
      total++;
      if (bus.repeating !== exp_r) begin
        bad++;
        $display("FAIL collision_repeating e%0d: got %b required %b", e, bus.repeating, exp_r);
      end
    end
    do_reset();
  endtask

  task automatic test_async_reset();
    logic exp_p;
    bus.btn_in = 1'b1;
    for (int e = 0; e < 20; e++) step();
    total++;
    if (bus.repeating !== 1'b1) begin
      bad++;
      $display("FAIL async_pre_rep: got %b required 1", bus.repeating);
    end
    #2;
    rst = 1'b1;
    #1;
    total++;
    if (bus.pulse !== 1'b0 || bus.btn_level !== 1'b0 || bus.repeating !== 1'b0) begin
      bad++;
      $display("FAIL async_reset_now: pulse=%b level=%b rep=%b required 0 0 0",
               bus.pulse, bus.btn_level, bus.repeating);
    end
    step();
    step();
    rst = 1'b0;
    for (int e = 0; e < 22; e++) begin
      step();
      exp_p = (e == 5) || (e == 15) || (e == 18) || (e == 21);
      total++;
      if (bus.pulse !== exp_p) begin
        bad++;
        $display("FAIL async_resume_pulse e%0d: got %b required %b", e, bus.pulse, exp_p);
      end
      total++;
      if (bus.repeating !== (e >= 15)) begin
        bad++;
        $display("FAIL async_resume_rep e%0d: got %b required %b", e, bus.repeating, (e >= 15));
      end
    end
    do_reset();
  endtask

  task automatic test_no_repeat();
    for (int e = 0; e < 30; e++) begin
      bus2.btn_in = 1'b1;
      step();
      total++;
      if (bus2.pulse !== (e == 5) || bus2.repeating !== 1'b0) begin
        bad++;
        $display("FAIL norep e%0d: pulse=%b rep=%b required %b 0",
                 e, bus2.pulse, bus2.repeating, (e == 5));
      end
    end
    do_reset();
  endtask

  initial begin
    total       = 0;
    bad         = 0;
    rst         = 1'b1;
    bus.btn_in  = 1'b0;
    bus2.btn_in = 1'b0;
    #1;
    test_reset();
    test_glitch(3, 1'b0);
    test_glitch(4, 1'b1);
    test_short_press();
    test_hold();
    test_release_collision();
    test_async_reset();
    test_no_repeat();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
